// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: MiniMIPS32 coprocessor-0 with exception/ERET/interrupt arbitration and fetch redirect.
// Define CP0_TIMER_IRQ_EN to add the Count==Compare timer interrupt (Cause.TI, folded into IP[7]).
module cp0_exc_unit #(
  parameter int          INT_NUM    = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic               cpu_clk_75M,
  input  logic               cpu_rst_n,
  input  logic               we_i,
  input  logic [4:0]         waddr_i,
  input  logic [31:0]        wdata_i,
  input  logic               re_i,
  input  logic [4:0]         raddr_i,
  output logic [31:0]        rdata_o,
  input  logic [INT_NUM-1:0] int_i,
  input  logic [4:0]         exc_code_i,
  input  logic [31:0]        exc_epc_i,
  input  logic [31:0]        exc_badvaddr_i,
  input  logic               in_delay_i,
  output logic               flush_o,
  output logic               exc_jump_flag_o,
  output logic [31:0]        exc_jump_addr_o,
  output logic               int_req_o,
  output logic [31:0]        status_o,
  output logic [31:0]        cause_o,
  output logic [31:0]        epc_o,
  output logic [31:0]        count_o,
  output logic [31:0]        compare_o,
  output logic [31:0]        badvaddr_o
);
  localparam logic [4:0] EXC_NONE     = 5'h10;
  localparam logic [4:0] EXC_ERET     = 5'h11;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [31:0] r_badvaddr, r_count, r_compare, r_epc, r_jump_addr;
  logic [7:0]  r_im;
  logic        r_exl, r_ie, r_bd, r_toggle, r_jump_flag;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;

  logic        w_exc, w_eret, w_wr, w_ti;
  logic [5:0]  w_int;
  logic [7:0]  w_ip;
  logic [31:0] w_status, w_cause, w_rview, w_wview, w_count_nxt;

  assign w_exc  = (exc_code_i != EXC_NONE) && (exc_code_i != EXC_ERET);
  assign w_eret = exc_code_i == EXC_ERET;
  // exception and ERET both take precedence over a concurrent MTC0
  assign w_wr   = we_i & ~w_exc & ~w_eret;
  assign w_int  = 6'(int_i);

  assign w_count_nxt = (w_wr && waddr_i == REG_COUNT) ? wdata_i : r_count + {31'b0, r_toggle};

`ifdef CP0_TIMER_IRQ_EN
  logic        r_ti;
  logic [31:0] w_compare_nxt;
  assign w_compare_nxt = (w_wr && waddr_i == REG_COMPARE) ? wdata_i : r_compare;
  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n)
    if (!cpu_rst_n)
      r_ti <= 1'b0;
    else
      r_ti <= (w_wr && waddr_i == REG_COMPARE) ? 1'b0 :
              r_ti | ((w_count_nxt == w_compare_nxt) && (w_compare_nxt != 32'd0));
  assign w_ti = r_ti;
`else
  assign w_ti = 1'b0;
`endif

  assign w_ip     = {r_ip_hw[5] | w_ti, r_ip_hw[4:0], r_ip_sw};
  assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_cause  = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};

  assign w_rview = raddr_i == REG_BADVADDR ? r_badvaddr :
                   raddr_i == REG_COUNT    ? r_count    :
                   raddr_i == REG_COMPARE  ? r_compare  :
                   raddr_i == REG_STATUS   ? w_status   :
                   raddr_i == REG_CAUSE    ? w_cause    :
                   raddr_i == REG_EPC      ? r_epc      : 32'd0;

  // value the written register will read back once the write mask is applied
  assign w_wview = waddr_i == REG_STATUS   ? {9'b0, 1'b1, 6'b0, wdata_i[15:8], 6'b0, wdata_i[1:0]} :
                   waddr_i == REG_CAUSE    ? {w_cause[31:10], wdata_i[9:8], w_cause[7:0]} :
                   waddr_i == REG_COUNT    ? wdata_i :
                   waddr_i == REG_COMPARE  ? wdata_i :
                   waddr_i == REG_EPC      ? wdata_i :
                   waddr_i == REG_BADVADDR ? r_badvaddr : 32'd0;

  assign rdata_o = !re_i ? 32'd0 : (we_i && waddr_i == raddr_i) ? w_wview : w_rview;

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n)
    if (!cpu_rst_n) begin
      r_badvaddr  <= '0;
      r_count     <= '0;
      r_compare   <= '0;
      r_epc       <= '0;
      r_jump_addr <= '0;
      r_jump_flag <= 1'b0;
      r_im        <= '0;
      r_exl       <= 1'b0;
      r_ie        <= 1'b0;
      r_bd        <= 1'b0;
      r_toggle    <= 1'b0;
      r_ip_hw     <= '0;
      r_ip_sw     <= '0;
      r_exccode   <= '0;
    end else begin
      r_toggle    <= (w_wr && waddr_i == REG_COUNT) ? 1'b0 : ~r_toggle;
      r_count     <= w_count_nxt;
      r_ip_hw     <= w_int;
      r_jump_flag <= w_exc | w_eret;
      r_jump_addr <= w_exc ? EXC_VECTOR : w_eret ? r_epc : 32'd0;
      if (w_wr && waddr_i == REG_COMPARE) r_compare <= wdata_i;
      if (w_wr && waddr_i == REG_CAUSE) r_ip_sw <= wdata_i[9:8];
      if (w_wr && waddr_i == REG_EPC) r_epc <= wdata_i;
      if (w_wr && waddr_i == REG_STATUS) begin
        r_im  <= wdata_i[15:8];
        r_exl <= wdata_i[1];
        r_ie  <= wdata_i[0];
      end
      if (w_exc) begin
        // nested exceptions keep the original return point
        if (!r_exl) begin
          r_epc <= in_delay_i ? exc_epc_i - 32'd4 : exc_epc_i;
          r_bd  <= in_delay_i;
        end
        r_exl     <= 1'b1;
        r_exccode <= exc_code_i;
        if (exc_code_i == 5'd4 || exc_code_i == 5'd5) r_badvaddr <= exc_badvaddr_i;
      end
      if (w_eret) r_exl <= 1'b0;
    end

  assign flush_o         = cpu_rst_n & (exc_code_i != EXC_NONE);
  assign exc_jump_flag_o = r_jump_flag;
  assign exc_jump_addr_o = r_jump_addr;
  assign int_req_o       = r_ie & ~r_exl & |(w_ip & r_im);
  assign status_o        = w_status;
  assign cause_o         = w_cause;
  assign epc_o           = r_epc;
  assign count_o         = r_count;
  assign compare_o       = r_compare;
  assign badvaddr_o      = r_badvaddr;
endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit: directed and randomized checks of cp0_exc_unit against a register-level reference model.
module tb_cp0_exc_unit;
  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam logic [31:0] BEV = 32'h0040_0000;
`ifdef CP0_TIMER_IRQ_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        we_i = 1'b0, re_i = 1'b0, in_delay_i = 1'b0;
  logic [4:0]  waddr_i = '0, raddr_i = '0, exc_code_i = 5'h10;
  logic [31:0] wdata_i = '0, exc_epc_i = '0, exc_badvaddr_i = '0;
  logic [5:0]  int_i = '0;
  logic [31:0] rdata_o, exc_jump_addr_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
  logic        flush_o, exc_jump_flag_o, int_req_o;
  int errors = 0, checks = 0;

  cp0_exc_unit dut (
    .cpu_clk_75M(clk), .cpu_rst_n(rst_n), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .re_i(re_i), .raddr_i(raddr_i), .rdata_o(rdata_o), .int_i(int_i), .exc_code_i(exc_code_i),
    .exc_epc_i(exc_epc_i), .exc_badvaddr_i(exc_badvaddr_i), .in_delay_i(in_delay_i),
    .flush_o(flush_o), .exc_jump_flag_o(exc_jump_flag_o), .exc_jump_addr_o(exc_jump_addr_o),
    .int_req_o(int_req_o), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .count_o(count_o), .compare_o(compare_o), .badvaddr_o(badvaddr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: architectural register contents, Count as base + elapsed/2
  logic [31:0] m_bad, m_base, m_cmp, m_status, m_epc, m_ja;
  int unsigned m_cyc;
  logic [5:0]  m_iphw;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;
  logic        m_bd, m_ti, m_jf;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_cyc / 2);
  endfunction

  function automatic logic [31:0] m_cause();
    logic ti;
    ti = TIMER & m_ti;
    return {m_bd, ti, 14'b0, m_iphw[5] | ti, m_iphw[4:0], m_ipsw, 1'b0, m_code, 2'b0};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_bad;
      5'd9:  return m_count();
      5'd11: return m_cmp;
      5'd12: return m_status;
      5'd13: return m_cause();
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_rdata();
    logic [31:0] c;
    if (!re_i) return 32'd0;
    if (!(we_i && waddr_i == raddr_i)) return m_read(raddr_i);
    c = m_cause();
    case (waddr_i)
      5'd12: return (wdata_i & 32'h0000FF03) | BEV;
      5'd13: return (c & ~32'h300) | (wdata_i & 32'h300);
      5'd9, 5'd11, 5'd14: return wdata_i;
      5'd8: return m_bad;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bad = 0; m_base = 0; m_cmp = 0; m_status = BEV; m_epc = 0; m_ja = 0; m_cyc = 0;
      m_iphw = 0; m_ipsw = 0; m_code = 0; m_bd = 0; m_ti = 0; m_jf = 0;
    end else begin
      automatic bit exc = exc_code_i != 5'h10 && exc_code_i != 5'h11;
      automatic bit eret = exc_code_i == 5'h11;
      automatic bit wr = we_i && !exc && !eret;
      automatic bit old_exl = m_status[1];
      m_jf = exc || eret;
      m_ja = exc ? VEC : eret ? m_epc : 32'd0;
      if (wr && waddr_i == 9) begin m_base = wdata_i; m_cyc = 0; end
      else m_cyc++;
      if (wr && waddr_i == 11) m_cmp = wdata_i;
      if (wr && waddr_i == 12) m_status = (wdata_i & 32'h0000FF03) | BEV;
      if (wr && waddr_i == 13) m_ipsw = wdata_i[9:8];
      if (wr && waddr_i == 14) m_epc = wdata_i;
      if (exc) begin
        if (!old_exl) begin
          m_epc = in_delay_i ? exc_epc_i - 4 : exc_epc_i;
          m_bd = in_delay_i;
        end
        m_status[1] = 1'b1;
        m_code = exc_code_i;
        if (exc_code_i == 4 || exc_code_i == 5) m_bad = exc_badvaddr_i;
      end
      if (eret) m_status[1] = 1'b0;
      m_iphw = int_i;
      if (wr && waddr_i == 11) m_ti = 1'b0;
      else if (m_count() == m_cmp && m_cmp != 0) m_ti = 1'b1;
    end
  end

  always @(negedge clk) if (rst_n) begin
    automatic logic [31:0] c = m_cause();
    chk("status", status_o, m_status);
    chk("cause", cause_o, c);
    chk("epc", epc_o, m_epc);
    chk("count", count_o, m_count());
    chk("compare", compare_o, m_cmp);
    chk("badvaddr", badvaddr_o, m_bad);
    chk("jump_flag", 32'(exc_jump_flag_o), 32'(m_jf));
    chk("jump_addr", exc_jump_addr_o, m_ja);
    chk("int_req", 32'(int_req_o), 32'(m_status[0] & ~m_status[1] & |(c[15:8] & m_status[15:8])));
    chk("flush", 32'(flush_o), 32'(exc_code_i != 5'h10));
    chk("rdata", rdata_o, m_rdata());
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] regs [6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    return $urandom_range(0, 7) == 0 ? 5'($urandom) : regs[$urandom_range(0, 5)];
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) step();
    chk("rst_status", status_o, 32'h0040_0000);
    chk("rst_count", count_o, 32'd5);
    chk("rst_cause", cause_o, 32'd0);
    chk("rst_epc", epc_o, 32'd0);
    chk("rst_jump", {exc_jump_flag_o, exc_jump_addr_o[30:0]}, 32'd0);
    we_i = 1; waddr_i = 12; wdata_i = 32'hFFFF_FFFF; re_i = 1; raddr_i = 12;
    #1 chk("fwd_status", rdata_o, 32'h0040_FF03);
    step(); we_i = 0;
    chk("status_mask", status_o, 32'h0040_FF03);
    we_i = 1; wdata_i = 32'h0000_0401; re_i = 0;
    step(); we_i = 0;
    exc_code_i = 5'h04; exc_epc_i = 32'hBFC0_0100; in_delay_i = 1; exc_badvaddr_i = 32'h1233;
    #1 chk("exc_flush", 32'(flush_o), 32'd1);
    step();
    chk("exc_jaddr", exc_jump_addr_o, 32'hBFC0_0380);
    chk("exc_epc", epc_o, 32'hBFC0_00FC);
    chk("exc_bd_code", {cause_o[31], 24'b0, cause_o[6:0]}, 32'h8000_0010);
    chk("exc_bad", badvaddr_o, 32'h1233);
    chk("exc_exl", 32'(status_o[1]), 32'd1);
    exc_code_i = 5'h0C; exc_epc_i = 32'h80; in_delay_i = 0;
    step();
    chk("nest_epc", epc_o, 32'hBFC0_00FC);
    exc_code_i = 5'h10;
    step();
    chk("idle_jump", {exc_jump_flag_o, exc_jump_addr_o[30:0]}, 32'd0);
    exc_code_i = 5'h11;
    step(); exc_code_i = 5'h10;
    chk("eret_flag", 32'(exc_jump_flag_o), 32'd1);
    chk("eret_addr", exc_jump_addr_o, 32'hBFC0_00FC);
    chk("eret_exl", 32'(status_o[1]), 32'd0);
    int_i = 6'd1;
    step(); step();
    chk("int_req_on", 32'(int_req_o), 32'd1);
    we_i = 1; waddr_i = 12; wdata_i = 32'h0000_0403;
    step(); we_i = 0;
    chk("int_req_exl", 32'(int_req_o), 32'd0);
    int_i = 0;
    exc_code_i = 5'h04;
    #1 rst_n = 0;
    #1 chk("rst_flush", 32'(flush_o), 32'd0);
    exc_code_i = 5'h10;
    step();
    chk("rst_lost_pulse", 32'(exc_jump_flag_o), 32'd0);
    chk("rst_mid_status", status_o, 32'h0040_0000);
    rst_n = 1;
`ifdef CP0_TIMER_IRQ_EN
    we_i = 1; waddr_i = 11; wdata_i = 6;
    step(); waddr_i = 9; wdata_i = 0;
    step(); we_i = 0;
    for (int i = 0; i < 40 && count_o != 6; i++) step();
    chk("timer_count", count_o, 32'd6);
    chk("timer_ti_ip7", {cause_o[30], 14'b0, cause_o[15], 15'b0}, 32'h4000_8000);
    we_i = 1; waddr_i = 11; wdata_i = 32'h100;
    step(); we_i = 0;
    chk("timer_clear", 32'(cause_o[30]), 32'd0);
`endif
    for (int i = 0; i < 3000; i++) begin
      automatic int r = $urandom_range(0, 99);
      exc_code_i = r < 8 ? 5'h11 : r < 20 ? 5'($urandom_range(0, 15)) : 5'h10;
      exc_epc_i = $urandom; exc_badvaddr_i = $urandom; in_delay_i = 1'($urandom);
      we_i = $urandom_range(0, 2) == 0;
      waddr_i = pick_reg();
      wdata_i = $urandom;
      if (waddr_i == 9 && $urandom_range(0, 1) == 0) wdata_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      if (waddr_i == 11 && $urandom_range(0, 1) == 0) wdata_i = count_o + 32'($urandom_range(0, 8));
      if (waddr_i == 12 && $urandom_range(0, 1) == 0) wdata_i[1] = 1'b0;
      re_i = 1'($urandom);
      raddr_i = $urandom_range(0, 1) ? waddr_i : pick_reg();
      if ($urandom_range(0, 9) == 0) int_i = 6'($urandom);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
